// File: rtl/healthcare_pkg.sv
// Shared thresholds, alarm bundle and detector helpers for the
// first-phase healthcare monitor.
package healthcare_pkg;

  localparam logic [2:0] PRESSURE_SYS_MAX = 3'd4;
  localparam logic [2:0] PRESSURE_DIA_MAX = 3'd6;
  localparam logic [3:0] PH_MIN           = 4'd7;
  localparam logic [3:0] PH_MAX           = 4'd9;
  localparam logic [8:0] TEMP_MIN         = 9'd35;
  localparam logic [8:0] TEMP_MAX         = 9'd39;
  localparam int unsigned TEMP_SHIFT      = 2;

  typedef struct packed {
    logic pressure;
    logic blood;
    logic fall;
    logic temp;
  } alarm_t;

  function automatic logic pressure_alarm(
    input logic [5:0] pd
  );
    return (pd[5:3] >= PRESSURE_SYS_MAX) ||
           (pd[2:0] >= PRESSURE_DIA_MAX);
  endfunction

  function automatic logic ph_alarm(
    input logic [3:0] ph
  );
    return (ph < PH_MIN) || (ph > PH_MAX);
  endfunction

endpackage

// File: rtl/temperature_abnormality_detector.sv
// Combinational temperature path: calibrate the raw reading and
// flag values outside the normal band (band edges are normal).
module temperature_abnormality_detector
  import healthcare_pkg::*;
(
  input  logic [7:0] base_temp,
  input  logic [3:0] temp_coef,
  input  logic [3:0] sensor,
  output logic       abnormal
);

  logic [7:0] prod;
  logic [8:0] scaled;
  logic [8:0] meas;

  assign prod   = {4'b0, temp_coef} * {4'b0, sensor};
  assign scaled = {1'b0, prod} >> TEMP_SHIFT;
  // 9 bits hold 255 + 56, so the sum never wraps
  assign meas   = {1'b0, base_temp} + scaled;

  assign abnormal = (meas < TEMP_MIN) || (meas > TEMP_MAX);

endmodule

// File: rtl/healthcare_system_first_phase.sv
// Registered alarm outputs for the healthcare monitor.
// Glycemic index output is built only with HEALTHCARE_GLYCEMIC_INDEX_EN.
module healthcare_system_first_phase
  import healthcare_pkg::*;
(
  input  logic       clk,
  input  logic       rstN,
  input  logic [5:0] pressureData,
  input  logic [3:0] bloodPH,
  input  logic [2:0] bloodType,
  input  logic [7:0] fdSensorValue,
  input  logic [7:0] fdFactoryValue,
  input  logic [7:0] bloodSensor,
  input  logic [7:0] factoryBaseTemp,
  input  logic [3:0] factoryTempCoef,
  input  logic [3:0] tempSensorValue,
  output logic       presureAbnormality,
  output logic       bloodAbnormality,
  output logic       fallDetected,
  output logic [3:0] glycemicIndex,
  output logic       temperatureAbnormality
);

  logic   temp_abn;
  alarm_t alarm_d;
  alarm_t alarm_q;
  logic   unused_bits;

  temperature_abnormality_detector u_temp (
    .base_temp (factoryBaseTemp),
    .temp_coef (factoryTempCoef),
    .sensor    (tempSensorValue),
    .abnormal  (temp_abn)
  );

  always_comb begin
    alarm_d          = '0;
    alarm_d.pressure = pressure_alarm(pressureData);
    alarm_d.blood    = ph_alarm(bloodPH);
    alarm_d.fall     = fdSensorValue >= fdFactoryValue;
    alarm_d.temp     = temp_abn;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      alarm_q <= '0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign presureAbnormality     = alarm_q.pressure;
  assign bloodAbnormality       = alarm_q.blood;
  assign fallDetected           = alarm_q.fall;
  assign temperatureAbnormality = alarm_q.temp;

`ifdef HEALTHCARE_GLYCEMIC_INDEX_EN
  logic [3:0] gly_d;
  logic [3:0] gly_q;

  always_comb begin
    gly_d = bloodSensor[7:4];
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      gly_q <= '0;
    end else begin
      gly_q <= gly_d;
    end
  end

  assign glycemicIndex = gly_q;
  // blood type has no role yet in this phase
  assign unused_bits   = ^{bloodType, bloodSensor[3:0]};
`else
  assign glycemicIndex = '0;
  assign unused_bits   = ^{bloodType, bloodSensor};
`endif

endmodule

// File: tb/tb_healthcare_system_first_phase.sv
// Directed vector bench for healthcare_system_first_phase.
module tb_healthcare_system_first_phase;

  logic       clk;
  logic       rstN;
  logic [5:0] pressureData;
  logic [3:0] bloodPH;
  logic [2:0] bloodType;
  logic [7:0] fdSensorValue;
  logic [7:0] fdFactoryValue;
  logic [7:0] bloodSensor;
  logic [7:0] factoryBaseTemp;
  logic [3:0] factoryTempCoef;
  logic [3:0] tempSensorValue;
  logic       presureAbnormality;
  logic       bloodAbnormality;
  logic       fallDetected;
  logic [3:0] glycemicIndex;
  logic       temperatureAbnormality;

  int n_checks = 0;
  int n_fail   = 0;

  healthcare_system_first_phase dut (
    .clk                    (clk),
    .rstN                   (rstN),
    .pressureData           (pressureData),
    .bloodPH                (bloodPH),
    .bloodType              (bloodType),
    .fdSensorValue          (fdSensorValue),
    .fdFactoryValue         (fdFactoryValue),
    .bloodSensor            (bloodSensor),
    .factoryBaseTemp        (factoryBaseTemp),
    .factoryTempCoef        (factoryTempCoef),
    .tempSensorValue        (tempSensorValue),
    .presureAbnormality     (presureAbnormality),
    .bloodAbnormality       (bloodAbnormality),
    .fallDetected           (fallDetected),
    .glycemicIndex          (glycemicIndex),
    .temperatureAbnormality (temperatureAbnormality)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] pd;
    logic [3:0] ph;
    logic [2:0] bt;
    logic [7:0] fs;
    logic [7:0] ff;
    logic [7:0] bs;
    logic [7:0] tb;
    logic [3:0] tc;
    logic [3:0] ts;
    logic       e_p;
    logic       e_b;
    logic       e_f;
    logic [3:0] e_g;
    logic       e_t;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [3:0] gi(input logic [3:0] v);
`ifdef HEALTHCARE_GLYCEMIC_INDEX_EN
    return v;
`else
    return 4'd0;
`endif
  endfunction

  task automatic check(
    input string      nm,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(
    input string      nm,
    input logic       p,
    input logic       b,
    input logic       f,
    input logic [3:0] g,
    input logic       t
  );
    check({nm, ".pressure"}, {7'b0, presureAbnormality}, {7'b0, p});
    check({nm, ".blood"}, {7'b0, bloodAbnormality}, {7'b0, b});
    check({nm, ".fall"}, {7'b0, fallDetected}, {7'b0, f});
    check({nm, ".glyc"}, {4'b0, glycemicIndex}, {4'b0, g});
    check({nm, ".temp"}, {7'b0, temperatureAbnormality}, {7'b0, t});
  endtask

  task automatic drive(input vec_t v);
    pressureData    = v.pd;
    bloodPH         = v.ph;
    bloodType       = v.bt;
    fdSensorValue   = v.fs;
    fdFactoryValue  = v.ff;
    bloodSensor     = v.bs;
    factoryBaseTemp = v.tb;
    factoryTempCoef = v.tc;
    tempSensorValue = v.ts;
  endtask

  function automatic vec_t mk(
    input string      nm,
    input logic [5:0] pd, input logic [3:0] ph,
    input logic [2:0] bt, input logic [7:0] fs,
    input logic [7:0] ff, input logic [7:0] bs,
    input logic [7:0] tb, input logic [3:0] tc,
    input logic [3:0] ts,
    input logic p, input logic b, input logic f,
    input logic [3:0] g, input logic t
  );
    vec_t v;
    v.name = nm; v.pd = pd; v.ph = ph; v.bt = bt;
    v.fs = fs; v.ff = ff; v.bs = bs;
    v.tb = tb; v.tc = tc; v.ts = ts;
    v.e_p = p; v.e_b = b; v.e_f = f;
    v.e_g = g; v.e_t = t;
    return v;
  endfunction

  initial begin
    // baseline: pressure 0/1, pH 8, no fall, glucose 0, temp 36
    vecs.push_back(mk("p_000001", 6'o01, 8, 0, 0, 10, 8'h00, 36, 0, 0,
                      0, 0, 0, gi(0), 0));
    vecs.push_back(mk("p_100001", 6'o41, 8, 0, 0, 10, 8'h00, 36, 0, 0,
                      1, 0, 0, gi(0), 0));
    vecs.push_back(mk("p_000110", 6'o06, 8, 0, 0, 10, 8'h00, 36, 0, 0,
                      1, 0, 0, gi(0), 0));
    vecs.push_back(mk("p_011101", 6'o35, 8, 0, 0, 10, 8'h00, 36, 0, 0,
                      0, 0, 0, gi(0), 0));
    vecs.push_back(mk("ph0", 6'o01, 0, 0, 0, 10, 8'h00, 36, 0, 0,
                      0, 1, 0, gi(0), 0));
    vecs.push_back(mk("ph8_t1", 6'o01, 8, 1, 0, 10, 8'h00, 36, 0, 0,
                      0, 0, 0, gi(0), 0));
    vecs.push_back(mk("ph7", 6'o01, 7, 5, 0, 10, 8'h00, 36, 0, 0,
                      0, 0, 0, gi(0), 0));
    vecs.push_back(mk("ph10", 6'o01, 10, 7, 0, 10, 8'h00, 36, 0, 0,
                      0, 1, 0, gi(0), 0));
    vecs.push_back(mk("ph9", 6'o01, 9, 2, 0, 10, 8'h00, 36, 0, 0,
                      0, 0, 0, gi(0), 0));
    vecs.push_back(mk("fd_eq", 6'o01, 8, 0, 10, 10, 8'h00, 36, 0, 0,
                      0, 0, 1, gi(0), 0));
    vecs.push_back(mk("fd_lt", 6'o01, 8, 0, 9, 10, 8'h00, 36, 0, 0,
                      0, 0, 0, gi(0), 0));
    vecs.push_back(mk("fd_max", 6'o01, 8, 0, 255, 0, 8'h00, 36, 0, 0,
                      0, 0, 1, gi(0), 0));
    vecs.push_back(mk("t_32", 6'o01, 8, 0, 0, 10, 8'h00, 30, 4, 2,
                      0, 0, 0, gi(0), 1));
    vecs.push_back(mk("t_37", 6'o01, 8, 0, 0, 10, 8'h00, 35, 4, 2,
                      0, 0, 0, gi(0), 0));
    vecs.push_back(mk("t_311", 6'o01, 8, 0, 0, 10, 8'h00, 255, 15, 15,
                      0, 0, 0, gi(0), 1));
    vecs.push_back(mk("t_35", 6'o01, 8, 0, 0, 10, 8'h00, 33, 4, 2,
                      0, 0, 0, gi(0), 0));
    vecs.push_back(mk("t_39", 6'o01, 8, 0, 0, 10, 8'h00, 35, 4, 4,
                      0, 0, 0, gi(0), 0));
    vecs.push_back(mk("t_40", 6'o01, 8, 0, 0, 10, 8'h00, 36, 4, 4,
                      0, 0, 0, gi(0), 1));
    vecs.push_back(mk("t_34", 6'o01, 8, 0, 0, 10, 8'h00, 34, 3, 1,
                      0, 0, 0, gi(0), 1));
    vecs.push_back(mk("g_a7", 6'o01, 8, 0, 0, 10, 8'hA7, 36, 0, 0,
                      0, 0, 0, gi(4'hA), 0));
    vecs.push_back(mk("g_0f", 6'o01, 8, 0, 0, 10, 8'h0F, 36, 0, 0,
                      0, 0, 0, gi(4'h0), 0));
    vecs.push_back(mk("all_on", 6'o77, 15, 3, 200, 100, 8'hF0, 0, 0, 0,
                      1, 1, 1, gi(4'hF), 1));

    // outputs must be cleared while reset is held, before any edge
    rstN = 1'b0;
    drive(vecs[21]);
    #2;
    check_all("rst_init", 0, 0, 0, 4'd0, 0);
    @(negedge clk);
    rstN = 1'b1;
    // first edge after release loads the current inputs
    @(posedge clk);
    #1;
    check_all("rst_release", 1, 1, 1, gi(4'hF), 1);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_all(vecs[i].name, vecs[i].e_p, vecs[i].e_b,
                vecs[i].e_f, vecs[i].e_g, vecs[i].e_t);
    end

    // registered: an input change must not show before the edge
    drive(vecs[0]);
    #1;
    check_all("latency_hold", 1, 1, 1, gi(4'hF), 1);
    @(posedge clk);
    #1;
    check_all("latency_upd", 0, 0, 0, gi(4'h0), 0);

    // mid-cycle asynchronous reset with all alarms set
    drive(vecs[21]);
    @(posedge clk);
    #2;
    check_all("pre_async", 1, 1, 1, gi(4'hF), 1);
    rstN = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 4'd0, 0);
    @(posedge clk);
    #1;
    check_all("rst_held", 0, 0, 0, 4'd0, 0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    check_all("rel_wait", 0, 0, 0, 4'd0, 0);
    @(posedge clk);
    #1;
    check_all("rel_load", 1, 1, 1, gi(4'hF), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/healthcare_system_first_phase.md
HEALTHCARE_SYSTEM_FIRST_PHASE -- requirements
Module: healthcare_system_first_phase

Interface
REQ-001 Port clk  input  1  single clock; all state updates on rising edge.
REQ-002 Port rstN  input  1  asynchronous, active-low reset.
REQ-003 Port pressureData  input  6  [5:3] systolic code, [2:0] diastolic code.
REQ-004 Port bloodPH  input  4  unsigned blood pH code.
REQ-005 Port bloodType  input  3  blood type code 0..7 (no effect on outputs in this phase).
REQ-006 Port fdSensorValue  input  8  fall-detector accelerometer reading, unsigned.
REQ-007 Port fdFactoryValue  input  8  fall-detector factory threshold, unsigned.
REQ-008 Port bloodSensor  input  8  raw glucose reading, unsigned.
REQ-009 Port factoryBaseTemp  input  8  factory base temperature, unsigned.
REQ-010 Port factoryTempCoef  input  4  factory temperature coefficient, unsigned.
REQ-011 Port tempSensorValue  input  4  raw temperature reading, unsigned.
REQ-012 Port presureAbnormality  output  1  pressure alarm.
REQ-013 Port bloodAbnormality  output  1  blood pH alarm.
REQ-014 Port fallDetected  output  1  fall alarm.
REQ-015 Port glycemicIndex  output  4  glycemic index.
REQ-016 Port temperatureAbnormality  output  1  temperature alarm.

Function
REQ-017 All outputs SHALL be registered: each input is sampled on a rising clk edge and its result appears after that edge (latency 1 cycle); no combinational input-to-output path.
REQ-018 presureAbnormality SHALL be 1 iff pressureData[5:3] >= 4 or pressureData[2:0] >= 6.
REQ-019 bloodAbnormality SHALL be 1 iff bloodPH < 7 or bloodPH > 9; bloodType is ignored.
REQ-020 fallDetected SHALL be 1 iff fdSensorValue >= fdFactoryValue (unsigned; equality counts as a fall).
REQ-021 glycemicIndex SHALL equal bloodSensor[7:4] (floor of bloodSensor/16; range 0..15, no saturation required).
REQ-022 The measured temperature SHALL be computed at 9-bit width as factoryBaseTemp + ((factoryTempCoef * tempSensorValue) >> 2), with the product 8 bits wide and no overflow or truncation.
REQ-023 temperatureAbnormality SHALL be 1 iff the measured temperature < 35 or > 39; 35 and 39 are normal.
REQ-024 The five detectors SHALL be independent; a change on one input group SHALL NOT affect any other output.

Reset
REQ-025 While rstN = 0, all outputs SHALL be 0 immediately, independent of clk.
REQ-026 After rstN deasserts, the first rising clk edge SHALL load outputs computed from the current inputs.
REQ-027 Reset asserted mid-operation SHALL clear all outputs asynchronously; no other state exists.

Configuration
REQ-028 Macro HEALTHCARE_GLYCEMIC_INDEX_EN defined: glycemicIndex SHALL behave per REQ-021.
REQ-029 Macro HEALTHCARE_GLYCEMIC_INDEX_EN undefined: glycemicIndex SHALL be constant 0, and no glycemic register SHALL be built; all other outputs are unchanged.

Structure
REQ-030 Package healthcare_pkg SHALL hold the thresholds: PRESSURE_SYS_MAX=4, PRESSURE_DIA_MAX=6, PH_MIN=7, PH_MAX=9, TEMP_MIN=35, TEMP_MAX=39, and the temperature shift of 2.
REQ-031 The temperature path SHALL be one combinational sub-module, temperature_abnormality_detector; the top instantiates it and holds all registers.

Verification (one clk period between stimuli; check one cycle later)
REQ-032 Pressure: pressureData=6'b000001 -> presureAbnormality=0; 6'b100001 -> 1; 6'b000110 -> 1.
REQ-033 Blood: bloodPH=0, bloodType=0 -> bloodAbnormality=1; bloodPH=8, bloodType=1 -> 0; bloodPH=7 -> 0; bloodPH=10 -> 1.
REQ-034 Fall: fdSensorValue=10, fdFactoryValue=10 -> fallDetected=1; fdSensorValue=9, fdFactoryValue=10 -> 0.
REQ-035 Temperature: base=30, coef=4, sensor=2 -> temperatureAbnormality=1; base=35, coef=4, sensor=2 -> 0; base=255, coef=15, sensor=15 -> 1 (no wrap).
REQ-036 Glycemic: bloodSensor=8'hA7 -> glycemicIndex=4'hA with macro defined, 0 without.
REQ-037 Reset: set all alarms to 1, then drive rstN=0 between edges -> all outputs 0 at once; release -> values return after the next edge.
